// File: rtl/hazard_scoreboard_if.sv
// Decode-to-hazard-unit bundle: decode fields in, stall/forwarding decisions and stall count out.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = 3,
    parameter int STALL_CNT_W = 16
);
    // Handshake: id_valid qualifies every id_* field in the same cycle; stall is the
    // same-cycle "not ready" answer, so an instruction moves on only when id_valid & ~stall.
    logic                   id_valid;
    logic [REG_ADDR_W-1:0]  id_rs;
    logic [REG_ADDR_W-1:0]  id_rt;
    logic                   id_rs_used;
    logic                   id_rt_used;
    logic [REG_ADDR_W-1:0]  id_rd;
    logic                   id_reg_wrt;
    logic                   id_is_load;
    logic                   mem_done;
    logic                   flush;
    logic                   stall;
    logic [1:0]             fwd_rs_sel;
    logic [1:0]             fwd_rt_sel;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_wrt, id_is_load, mem_done, flush,
        input  stall, fwd_rs_sel, fwd_rt_sel, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd,
               id_reg_wrt, id_is_load, mem_done, flush,
        output stall, fwd_rs_sel, fwd_rt_sel, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage data-hazard unit: shift-register scoreboard of in-flight destinations.
// Define FORWARD_BYPASS_EN for load-use-only stalls with forwarding selects; default stalls on every match.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 3,
    parameter int DEPTH       = 2,   // legal range 1..3 (fits the 2-bit selects)
    parameter int STALL_CNT_W = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    logic [DEPTH:1]          sb_wr;
    logic [REG_ADDR_W-1:0]   sb_rd [1:DEPTH];
    logic [DEPTH:1]          rs_match;
    logic [DEPTH:1]          rt_match;
    logic                    haz;
    logic                    stall;
    logic                    accept;
    logic [1:0]              rs_sel;
    logic [1:0]              rt_sel;
    logic [STALL_CNT_W-1:0]  stall_count;

    always_comb begin
        rs_match = '0;
        rt_match = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            rs_match[k] = sb_wr[k] & (sb_rd[k] == bus.id_rs) & bus.id_rs_used;
            rt_match[k] = sb_wr[k] & (sb_rd[k] == bus.id_rt) & bus.id_rt_used;
        end
    end

`ifdef FORWARD_BYPASS_EN
    logic [DEPTH:1] sb_ld;

    // Only a load one stage ahead cannot be bypassed; everything else forwards.
    assign haz = sb_ld[1] & (rs_match[1] | rt_match[1]);

    // Scan oldest to youngest so the youngest producer overrides.
    always_comb begin
        rs_sel = '0;
        rt_sel = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rs_match[k]) rs_sel = 2'(k);
            if (rt_match[k]) rt_sel = 2'(k);
        end
        if (stall) begin
            rs_sel = '0;
            rt_sel = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_ld <= '0;
        end else if (bus.mem_done) begin
            for (int k = DEPTH; k >= 2; k--) sb_ld[k] <= sb_ld[k-1];
            sb_ld[1] <= accept & bus.id_is_load;
        end
    end
`else
    logic unused_ld;

    assign haz       = (|rs_match) | (|rt_match);
    assign rs_sel    = '0;
    assign rt_sel    = '0;
    assign unused_ld = bus.id_is_load;
`endif

    assign stall  = ~bus.mem_done | (bus.id_valid & ~bus.flush & haz);
    assign accept = bus.id_valid & ~bus.flush & ~haz;

    // A frozen memory holds every entry; otherwise a stalled or flushed slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_wr <= '0;
            for (int k = 1; k <= DEPTH; k++) sb_rd[k] <= '0;
        end else if (bus.mem_done) begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_wr[k] <= sb_wr[k-1];
                sb_rd[k] <= sb_rd[k-1];
            end
            sb_wr[1] <= accept & bus.id_reg_wrt;
            sb_rd[1] <= accept ? bus.id_rd : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && bus.id_valid && !(&stall_count)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_rs_sel  = rs_sel;
    assign bus.fwd_rt_sel  = rt_sel;
    assign bus.stall_count = stall_count;
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised data-hazard unit for the decode stage of the pipelined core. It tracks destination registers of the DEPTH instructions in flight past decode in an internal shift-register scoreboard. Each cycle it raises a stall for decode or, when forwarding is compiled in, selects a forwarding source. It also folds the data-memory not-done freeze into the stall and keeps a saturating stall-cycle counter.

## Interface
- REG_ADDR_W, 3: register-specifier width.
- DEPTH, 2: in-flight stages tracked after decode; legal range 1..3.
- STALL_CNT_W, 16: stall counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- id_valid  in  1  decode holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_W  source specifiers.
- id_rs_used, id_rt_used  in  1  the source is actually read.
- id_rd  in  REG_ADDR_W  destination specifier.
- id_reg_wrt  in  1  instruction writes id_rd.
- id_is_load  in  1  instruction is a load.
- mem_done  in  1  data memory complete; 0 freezes the pipeline.
- flush  in  1  kill the instruction in decode.
- stall  out  1  hold fetch/decode and inject a bubble.
- fwd_rs_sel, fwd_rt_sel  out  2  forwarding source: 0 = register file, k = stage k.
- stall_count  out  STALL_CNT_W  saturating count of stalled valid-decode cycles.

## Operation
- Scoreboard entries s[1..DEPTH], each {wr, rd, ld}. s[1] is the stage directly after decode.
- match_k(src) = s[k].wr & (s[k].rd == src) & src_used.
- haz without forwarding: any match_k on rs or rt, for any k.
- haz with forwarding: a match_1 where s[1].ld = 1 (load-use only).
- stall = ~mem_done | (id_valid & ~flush & haz). This is combinational from registered state and inputs.
- Update when mem_done = 1:
  - s[k] <= s[k-1] for k ≥ 2.
  - s[1] <= {id_reg_wrt, id_rd, id_is_load} if id_valid & ~flush & ~haz; otherwise s[1] <= bubble {0,0,0}.
- Update when mem_done = 0: all entries hold. flush is ignored; upstream holds flush until mem_done = 1.
- fwd_*_sel: the smallest k with match_k, so the youngest producer wins. The value is 0 if there is no match or a stall is asserted.
- stall_count increments when stall & id_valid and saturates at all-ones.
- Reset: all entries cleared, stall_count = 0. Outputs then follow the equations above: stall = ~mem_done and fwd sels = 0.

## Timing
- Stall and forwarding decisions take effect in the same cycle; the scoreboard advances on the next edge.
- A producer in decode at cycle t occupies s[1] at t+1, s[2] at t+2, and so on, and leaves after s[DEPTH].
- Without forwarding, a back-to-back consumer stalls DEPTH cycles and proceeds at t+DEPTH+1.
- With forwarding, a back-to-back ALU consumer has no stall. A load-use consumer stalls 1 cycle, then gets sel = 2.
- Freeze (mem_done = 0) adds cycles without losing entries; the hazard resolves as if time paused.
- Reset asserted mid-stall clears all tracking the next edge. Counting restarts from 0.
- Same specifier on rs and rt: both sels report the same k.

## Configuration
- FORWARD_BYPASS_EN defined: load-use-only hazard rule; fwd_rs_sel and fwd_rt_sel are driven.
- FORWARD_BYPASS_EN undefined: every match stalls; fwd_rs_sel and fwd_rt_sel are tied to 0. This is the default.

## Test plan
DEPTH = 2, REG_ADDR_W = 3, mem_done = 1 unless stated.
- Reset: rst_n = 0 for 2 cycles, then release with id_valid = 0 -> stall = 0, stall_count = 0, sels = 0, and the scoreboard is empty (no stall when reading r0..r7).
- No forwarding: write r3 at cycle 0; at cycle 1, read rs = r3 -> stall = 1 in cycles 1–2, 0 in cycle 3; stall_count = 2.
- Forwarding ALU: same stimulus -> no stall, fwd_rs_sel = 1 at cycle 1. A second r3 reader at cycle 2 -> fwd_rs_sel = 2.
- Forwarding load-use: load r5 at cycle 0; at cycle 1, read rt = r5 -> stall for 1 cycle, then fwd_rt_sel = 2 at cycle 2. With id_rt_used = 0 -> no stall.
- Freeze: mem_done = 0 for cycles 1–3 during the no-forwarding case -> stall stays high, the entry is held, release occurs at cycle 6, stall_count = 5.
- Flush/saturation: flush with a pending hazard -> stall = 0 and a bubble enters s[1]. Separately, with STALL_CNT_W = 2 and 5 stalled cycles -> stall_count = 3.
